// File: rtl/hilo_pkg.sv
// Shared types and helpers for the HI/LO register pair and its multiply-accumulate engine.
package hilo_pkg;

    typedef enum logic [1:0] {
        MADD  = 2'd0,
        MADDU = 2'd1,
        MSUB  = 2'd2,
        MSUBU = 2'd3
    } acc_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUL    = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int MAX_DATA_W = 64;
    localparam logic [MAX_DATA_W-1:0] ZERO_WORD = '0;

    function automatic logic is_signed(acc_op_t op);
        return (op == MADD) || (op == MSUB);
    endfunction

    function automatic logic is_sub(acc_op_t op);
        return (op == MSUB) || (op == MSUBU);
    endfunction

endpackage

// File: rtl/hilo_mul_pipe.sv
// Sign-selectable DATA_W x DATA_W multiplier followed by ACC_STAGES register stages.
module hilo_mul_pipe #(
    parameter int DATA_W     = 32,
    parameter int ACC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sgn,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic [2*DATA_W-1:0]   prod
);

    logic signed [2*DATA_W-1:0] a_ext;
    logic signed [2*DATA_W-1:0] b_ext;
    logic signed [2*DATA_W-1:0] full;
    logic [2*DATA_W-1:0]        stage_reg [ACC_STAGES];

    // Extending both operands to the full product width lets one signed multiply
    // serve both modes: the low 2*DATA_W bits are exact either way.
    assign a_ext = signed'({{DATA_W{sgn & a[DATA_W-1]}}, a});
    assign b_ext = signed'({{DATA_W{sgn & b[DATA_W-1]}}, b});
    assign full  = a_ext * b_ext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ACC_STAGES; i++) begin
                stage_reg[i] <= '0;
            end
        end else begin
            stage_reg[0] <= full;
            for (int i = 1; i < ACC_STAGES; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign prod = stage_reg[ACC_STAGES-1];

endmodule

// File: rtl/hilo_acc_unit.sv
// HI/LO register pair with direct per-half writes, read bypass and a multi-cycle
// MADD/MADDU/MSUB/MSUBU engine that commits both halves at once.
module hilo_acc_unit
    import hilo_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ACC_STAGES = 2,
    parameter int BYPASS     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_hi,
    input  logic                we_lo,
    input  logic [DATA_W-1:0]   hi_i,
    input  logic [DATA_W-1:0]   lo_i,
    input  logic                acc_valid,
    input  logic [1:0]          acc_op,
    input  logic [DATA_W-1:0]   acc_a,
    input  logic [DATA_W-1:0]   acc_b,
    input  logic                flush,
    output logic                acc_ready,
    output logic                acc_busy,
    output logic                acc_done,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o
);

    localparam int CNT_W = $clog2(ACC_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACC_STAGES - 1);

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    acc_op_t              op_reg;
    logic [DATA_W-1:0]    a_reg, b_reg;
    logic [DATA_W-1:0]    hi_reg, lo_reg;
    logic [DATA_W-1:0]    hi_fwd, lo_fwd;
    logic [2*DATA_W-1:0]  prod, base, acc;
    logic                 accept;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        acc_done   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (acc_valid && !flush) begin
                    accept     = 1'b1;
                    cnt_next   = CNT_INIT;
                    state_next = MUL;
                end
            end
            MUL: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (cnt_reg == '0) begin
                    state_next = COMMIT;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            COMMIT: begin
                acc_done   = !flush;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            op_reg    <= MADD;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                op_reg <= acc_op_t'(acc_op);
                a_reg  <= acc_a;
                b_reg  <= acc_b;
            end
        end
    end

    // Operands stay frozen in a_reg/b_reg, so the pipe output is stable by COMMIT.
    hilo_mul_pipe #(
        .DATA_W     (DATA_W),
        .ACC_STAGES (ACC_STAGES)
    ) u_mul_pipe (
        .clk  (clk),
        .rst  (rst),
        .sgn  (is_signed(op_reg)),
        .a    (a_reg),
        .b    (b_reg),
        .prod (prod)
    );

    assign hi_fwd = we_hi ? hi_i : hi_reg;
    assign lo_fwd = we_lo ? lo_i : lo_reg;
    // The accumulate base always folds in a same-cycle direct write, independent of BYPASS.
    assign base   = {hi_fwd, lo_fwd};
    assign acc    = is_sub(op_reg) ? (base - prod) : (base + prod);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (acc_done) begin
            {hi_reg, lo_reg} <= acc;
        end else begin
            if (we_hi) hi_reg <= hi_i;
            if (we_lo) lo_reg <= lo_i;
        end
    end

    assign acc_busy  = (state_reg != IDLE);
    assign acc_ready = ~acc_busy;

    generate
        if (BYPASS != 0) begin : g_bypass
            assign hi_o = rst ? hi_fwd : ZERO_WORD[DATA_W-1:0];
            assign lo_o = rst ? lo_fwd : ZERO_WORD[DATA_W-1:0];
        end else begin : g_no_bypass
            assign hi_o = hi_reg;
            assign lo_o = lo_reg;
        end
    endgenerate

endmodule

// File: tb/tb_hilo_acc_unit.sv
// Directed bench for hilo_acc_unit (DATA_W=32, ACC_STAGES=2, BYPASS=1).
module tb_hilo_acc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_hi, we_lo;
    logic [31:0] hi_i, lo_i;
    logic        acc_valid;
    logic [1:0]  acc_op;
    logic [31:0] acc_a, acc_b;
    logic        flush;
    logic        acc_ready, acc_busy, acc_done;
    logic [31:0] hi_o, lo_o;

    int check_cnt = 0;
    int err_cnt   = 0;
    int done_cnt;

    always #5 clk = ~clk;

    hilo_acc_unit #(
        .DATA_W     (32),
        .ACC_STAGES (2),
        .BYPASS     (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .we_hi     (we_hi),
        .we_lo     (we_lo),
        .hi_i      (hi_i),
        .lo_i      (lo_i),
        .acc_valid (acc_valid),
        .acc_op    (acc_op),
        .acc_a     (acc_a),
        .acc_b     (acc_b),
        .flush     (flush),
        .acc_ready (acc_ready),
        .acc_busy  (acc_busy),
        .acc_done  (acc_done),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
        @(negedge clk);
        we_hi = 1'b1; we_lo = 1'b1; hi_i = h; lo_i = l;
        @(negedge clk);
        we_hi = 1'b0; we_lo = 1'b0;
    endtask

    // Issue one op, wait (bounded) for acc_done, then check latency and the committed result.
    task automatic do_acc(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int   waited = 0;
        logic seen   = 1'b0;
        @(negedge clk);
        acc_valid = 1'b1; acc_op = op; acc_a = a; acc_b = b;
        @(negedge clk);
        acc_valid = 1'b0; acc_a = ~a; acc_b = ~b; acc_op = ~op;
        while (!seen && waited < 10) begin
            #1;
            if (acc_done) seen = 1'b1;
            else begin
                @(negedge clk);
                waited++;
            end
        end
        check({tag, "_done"}, {63'd0, acc_done}, 64'd1);
        check({tag, "_lat"}, 64'(waited), 64'd2);
        @(negedge clk);
        #1;
        check({tag, "_res"}, {hi_o, lo_o}, {eh, el});
    endtask

    initial begin
        rst = 1'b0; we_hi = 1'b0; we_lo = 1'b0; hi_i = '0; lo_i = '0;
        acc_valid = 1'b0; acc_op = 2'd0; acc_a = '0; acc_b = '0; flush = 1'b0;
        #1;
        check("rst_hilo", {hi_o, lo_o}, 64'd0);
        check("rst_flags", {61'd0, acc_ready, acc_busy, acc_done}, {61'd0, 3'b100});
        @(negedge clk);
        rst = 1'b1;

        // 1: async reset clears everything without a clock edge
        write_hilo(32'hDEAD, 32'hBEEF);
        #1;
        check("t1_loaded", {hi_o, lo_o}, {32'hDEAD, 32'hBEEF});
        #1;
        rst = 1'b0;
        #1;
        check("t1_async_hilo", {hi_o, lo_o}, 64'd0);
        check("t1_async_ready", {63'd0, acc_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b1;

        // 2: HI-only write is bypassed in the same cycle and then held
        @(negedge clk);
        we_hi = 1'b1; hi_i = 32'h12345678;
        #1;
        check("t2_bypass", {hi_o, lo_o}, {32'h12345678, 32'h0});
        @(negedge clk);
        we_hi = 1'b0; hi_i = 32'hFFFF0000;
        #1;
        check("t2_held", {hi_o, lo_o}, {32'h12345678, 32'h0});

        // 3: MADDU with cycle-by-cycle busy/done
        write_hilo(32'h0, 32'h5);
        @(negedge clk);
        acc_valid = 1'b1; acc_op = 2'd1; acc_a = 32'hFFFFFFFF; acc_b = 32'd2;
        #1;
        check("t3_c0_ready", {63'd0, acc_ready}, 64'd1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                acc_valid = 1'b0; acc_a = 32'h1234; acc_op = 2'd2;
            end
            #1;
            check($sformatf("t3_c%0d_busy_done", c), {62'd0, acc_busy, acc_done},
                  {62'd0, (c <= 3), (c == 3)});
        end
        check("t3_res", {hi_o, lo_o}, {32'h2, 32'h3});

        // 4: signed MSUB and MADD with a negative multiplicand
        write_hilo(32'h0, 32'h0);
        do_acc("t4_msub", 2'd2, 32'hFFFFFFFD, 32'd4, 32'h0, 32'hC);
        write_hilo(32'h0, 32'h0);
        do_acc("t4_madd", 2'd0, 32'hFFFFFFFD, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFF4);

        // 5: direct LO write folded into COMMIT; re-request during MUL ignored
        write_hilo(32'h0, 32'h0);
        done_cnt = 0;
        @(negedge clk);
        acc_valid = 1'b1; acc_op = 2'd0; acc_a = 32'd1; acc_b = 32'd1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin acc_a = 32'd5; acc_b = 32'd5; end
            if (c == 3) begin acc_valid = 1'b0; we_lo = 1'b1; lo_i = 32'h10; end
            if (c == 4) we_lo = 1'b0;
            #1;
            if (acc_done) done_cnt++;
            if (c == 4) check("t5_res", {hi_o, lo_o}, {32'h0, 32'h11});
        end
        check("t5_one_done", 64'(done_cnt), 64'd1);

        // 6: flush in MUL drops the op; flush with valid in IDLE drops the request
        done_cnt = 0;
        @(negedge clk);
        acc_valid = 1'b1; acc_op = 2'd0; acc_a = 32'd7; acc_b = 32'd7;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            acc_valid = 1'b0;
            flush = (c == 1);
            #1;
            if (acc_done) done_cnt++;
            if (c == 2) check("t6_ready_after_flush", {63'd0, acc_ready}, 64'd1);
        end
        check("t6_no_done", 64'(done_cnt), 64'd0);
        check("t6_hilo_kept", {hi_o, lo_o}, {32'h0, 32'h11});
        @(negedge clk);
        acc_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        acc_valid = 1'b0; flush = 1'b0;
        #1;
        check("t6_idle_flush_drop", {63'd0, acc_busy}, 64'd0);

        // 6b: reset asserted mid-MUL loses the result
        @(negedge clk);
        acc_valid = 1'b1; acc_op = 2'd0; acc_a = 32'd3; acc_b = 32'd3;
        @(negedge clk);
        acc_valid = 1'b0;
        #1;
        check("t6_mul_busy", {63'd0, acc_busy}, 64'd1);
        rst = 1'b0;
        #1;
        check("t6_rst_hilo", {hi_o, lo_o}, 64'd0);
        check("t6_rst_busy", {63'd0, acc_busy}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            if (acc_done) done_cnt++;
        end
        check("t6_rst_no_done", 64'(done_cnt), 64'd0);
        check("t6_rst_hilo_after", {hi_o, lo_o}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
